hazard_scoreboard_ctrl: RTL and testbench
=========================================

// Module: hazard_scoreboard_ctrl
// PURPOSE
//  Pipeline controller for the decode stage. Tracks in-flight register writes
//  in a per-register scoreboard and asserts hazard (stall IF/ID, bubble into
//  ID/EX) on RAW conflicts. Sequences the multi-cycle flush after a taken
//  branch, keeps stall/flush performance counters, and flags scoreboard errors.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles flush stays high per taken branch (1..7)
//  MAX_INFLIGHT  3   max pending writes per register (EXE, MEM, WB); 2-bit counters
//  CNT_W         16  width of the saturating perf counters
// PORTS
//  clk            in   1      clock; all state updates on the rising edge
//  rst            in   1      reset; one clock, reset is asynchronous and active-low
//  id_valid       in   1      ID holds a real instruction (not a bubble)
//  id_rn          in   4      ID source register 1
//  id_rm          in   4      ID source register 2
//  id_two_src     in   1      id_rm is read by the ID instruction
//  id_wb_en       in   1      ID instruction writes id_dest
//  id_dest        in   4      ID destination register
//  branch_taken   in   1      taken branch resolved in EXE this cycle
//  wb_enable_in   in   1      WB stage writes the register file this cycle
//  wb_dest        in   4      WB destination register
//  hazard         out  1      stall IF and PC, insert bubble into ID/EX
//  flush          out  1      clear IF/ID and ID/EX registers
//  sb_busy        out  16     bit r = 1 while register r has a pending write
//  stall_count    out  CNT_W  cycles with hazard=1, saturating
//  flush_count    out  CNT_W  taken branches accepted, saturating
//  err            out  1      sticky: counter over/underflow
// BEHAVIOUR
//  Reset (rst=0, async): all pend[r]=0, FSM=IDLE, rem=0, counters=0, err=0.
//   Outputs during reset: hazard=0, flush=0, sb_busy=0.
//  Scoreboard: pend[0..15], 2 bits each. sb_busy[r] = |pend[r].
//  hazard (combinational from registered pend only):
//   hazard = id_valid & ~flush & (busy[id_rn] | (id_two_src & busy[id_rm])).
//   A retire in cycle t clears the hazard in t+1, never in t.
//  issue = id_valid & id_wb_en & ~hazard & ~flush.
//  retire = wb_enable_in.
//  Update: pend[id_dest] += issue and pend[wb_dest] -= retire.
//   If issue and retire hit the same register, the net count is unchanged.
//  Increment at MAX_INFLIGHT: saturate, set err. Decrement at 0: hold 0, set err.
//  Flush FSM (IDLE, FLUSH), with 3-bit rem:
//   IDLE + branch_taken: flush=1 this cycle.
//    If FLUSH_CYCLES>1, go to FLUSH with rem=FLUSH_CYCLES-1; else stay IDLE.
//   FLUSH: flush=1, rem decrements each cycle. Go to IDLE when rem==1.
//    branch_taken while in FLUSH is ignored (wrong-path bubble); no restart, no count.
//   flush = branch_taken_accepted | (state==FLUSH).
//   flush overrides hazard: hazard is forced to 0 while flush=1.
//  stall_count += hazard. flush_count += accepted branch. Both stick at all-ones.
//  err clears only on reset. No other output depends on err.
//  Flushed ID instructions never issue, so the scoreboard needs no rollback.
// STRUCTURE
//  Shared package (pipe_ctrl_pkg): REG_IDX_W=4, NUM_REGS=16, and the flush FSM
//   state encoding (IDLE=1'b0, FLUSH=1'b1).
//  One sub-module: sat_counter (width param, inc, sat-high). Used for both perf
//   counters.
//  Keep pend[] inline as a reg array with a generate loop.
// TESTING
//  1. Reset: rst=0 mid-flush with pend[3]=2.
//     -> hazard=0, flush=0, sb_busy=0, counters=0 immediately.
//  2. RAW: issue dest=R2, then ID reads rn=R2.
//     -> hazard=1 until cycle after WB of R2; stall_count equals stall cycles.
//  3. Same cycle: issue dest=R5 while WB retires R5 (pend[5]=1).
//     -> pend[5] stays 1, err=0.
//  4. FLUSH_CYCLES=3: branch_taken at t, again at t+1.
//     -> flush=1 for t..t+2 only; flush_count=1.
//  5. Flush vs hazard: branch_taken while a RAW stall is pending.
//     -> hazard=0, flush=1, no issue; pend unchanged.
//  6. Error: retire R7 with pend[7]=0. -> err=1, pend[7]=0; err holds until reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the decode-stage pipeline controller: register file
// geometry and the flush sequencer state encoding.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 16;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/hazard_scoreboard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; used for the stall and flush
// performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage controller: per-register write scoreboard with RAW stall,
// multi-cycle flush sequencing after taken branches, and perf counters.
module hazard_scoreboard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rn,
  input  logic [REG_IDX_W-1:0] id_rm,
  input  logic                 id_two_src,
  input  logic                 id_wb_en,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic                 branch_taken,
  input  logic                 wb_enable_in,
  input  logic [REG_IDX_W-1:0] wb_dest,
  output logic                 hazard,
  output logic                 flush,
  output logic [NUM_REGS-1:0]  sb_busy,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count,
  output logic                 err
);

  localparam logic [1:0] PEND_MAX = 2'(MAX_INFLIGHT);
  localparam logic [2:0] REM_INIT = 3'(FLUSH_CYCLES - 1);

  logic [0:0]          state;
  logic [2:0]          rem;
  logic                accept;
  logic                issue;
  logic                retire;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] err_set;

  // A branch arriving while already flushing is on the wrong path and is dropped.
  assign accept = branch_taken & (state == ST_IDLE);
  // Gated by reset so flush reads low even with branch_taken held during reset.
  assign flush  = rst & (accept | (state == ST_FLUSH));
  assign hazard = id_valid & ~flush & (busy[id_rn] | (id_two_src & busy[id_rm]));
  assign issue  = id_valid & id_wb_en & ~hazard & ~flush;
  assign retire = wb_enable_in;

  assign sb_busy = busy;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    logic [1:0] pend;
    logic       inc;
    logic       dec;

    assign inc        = issue  & (id_dest == REG_IDX_W'(r));
    assign dec        = retire & (wb_dest == REG_IDX_W'(r));
    assign busy[r]    = |pend;
    assign err_set[r] = (inc & ~dec & (pend == PEND_MAX)) |
                        (dec & ~inc & (pend == 2'd0));

    // Issue and retire on the same register cancel out.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pend <= 2'd0;
      end else if (inc && !dec && (pend != PEND_MAX)) begin
        pend <= pend + 2'd1;
      end else if (dec && !inc && (pend != 2'd0)) begin
        pend <= pend - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      rem   <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (FLUSH_CYCLES > 1)) begin
            state <= ST_FLUSH;
            rem   <= REM_INIT;
          end
        end
        default: begin
          rem <= rem - 3'd1;
          if (rem == 3'd1) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (|err_set) begin
      err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (hazard),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (accept),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed-vector bench: stimulus queues per-cycle expected outputs, a monitor
// compares them at the falling edge of the matching cycle.
module tb_hazard_scoreboard_ctrl;

  localparam int K_HAZ   = 0;
  localparam int K_FLUSH = 1;
  localparam int K_BUSY  = 2;
  localparam int K_STALL = 3;
  localparam int K_FCNT  = 4;
  localparam int K_ERR   = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_rn;
  logic [3:0]  id_rm;
  logic        id_two_src;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic        branch_taken;
  logic        wb_enable_in;
  logic [3:0]  wb_dest;
  logic        hazard;
  logic        flush;
  logic [15:0] sb_busy;
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic        err;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  hazard_scoreboard_ctrl #(
    .FLUSH_CYCLES (3),
    .MAX_INFLIGHT (3),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_two_src   (id_two_src),
    .id_wb_en     (id_wb_en),
    .id_dest      (id_dest),
    .branch_taken (branch_taken),
    .wb_enable_in (wb_enable_in),
    .wb_dest      (wb_dest),
    .hazard       (hazard),
    .flush        (flush),
    .sb_busy      (sb_busy),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                       input logic two, input logic wbe, input logic [3:0] dest,
                       input logic br, input logic wbin, input logic [3:0] wbd);
    id_valid     = v;
    id_rn        = rn;
    id_rm        = rm;
    id_two_src   = two;
    id_wb_en     = wbe;
    id_dest      = dest;
    branch_taken = br;
    wb_enable_in = wbin;
    wb_dest      = wbd;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic expect_out(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_HAZ:   act = 32'(hazard);
          K_FLUSH: act = 32'(flush);
          K_BUSY:  act = 32'(sb_busy);
          K_STALL: act = 32'(stall_count);
          K_FCNT:  act = 32'(flush_count);
          default: act = 32'(err);
        endcase
        vectors++;
        if (act !== e.val) begin
          miscompares++;
          $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", e.name, e.cyc, act, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    expect_out(K_HAZ, 0, "post_reset_hazard");
    expect_out(K_FLUSH, 0, "post_reset_flush");
    expect_out(K_BUSY, 0, "post_reset_busy");
    expect_out(K_STALL, 0, "post_reset_stall");
    expect_out(K_ERR, 0, "post_reset_err");
    nxt();

    // RAW on rn: issue R2, read R2, retire R2 while still stalled
    drive(1, 4'd0, 4'd0, 0, 1, 4'd2, 0, 0, 4'd0);
    expect_out(K_HAZ, 0, "raw_issue_r2");
    nxt();
    drive(1, 4'd2, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0);
    expect_out(K_HAZ, 1, "raw_stall_r2");
    expect_out(K_BUSY, 32'h0004, "raw_busy_r2");
    nxt();
    drive(1, 4'd2, 4'd0, 0, 0, 4'd0, 0, 1, 4'd2);
    expect_out(K_HAZ, 1, "raw_stall_during_wb");
    nxt();
    idle();
    expect_out(K_HAZ, 0, "raw_cleared");
    expect_out(K_BUSY, 0, "raw_busy_cleared");
    expect_out(K_STALL, 2, "raw_stall_count");
    nxt();

    // RAW on rm depends on id_two_src
    drive(1, 4'd0, 4'd0, 0, 1, 4'd9, 0, 0, 4'd0);
    nxt();
    drive(1, 4'd0, 4'd9, 0, 0, 4'd0, 0, 0, 4'd0);
    expect_out(K_HAZ, 0, "rm_ignored_one_src");
    expect_out(K_BUSY, 32'h0200, "rm_busy_r9");
    nxt();
    drive(1, 4'd0, 4'd9, 1, 0, 4'd0, 0, 1, 4'd9);
    expect_out(K_HAZ, 1, "rm_stall_two_src");
    nxt();
    idle();
    expect_out(K_HAZ, 0, "rm_cleared");
    expect_out(K_STALL, 3, "rm_stall_count");
    nxt();

    // Same-cycle issue and retire of R5 with one write pending
    drive(1, 4'd0, 4'd0, 0, 1, 4'd5, 0, 0, 4'd0);
    nxt();
    drive(1, 4'd0, 4'd0, 0, 1, 4'd5, 0, 1, 4'd5);
    expect_out(K_HAZ, 0, "same_cycle_no_hazard");
    nxt();
    drive(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd5);
    expect_out(K_BUSY, 32'h0020, "same_cycle_busy_r5");
    expect_out(K_ERR, 0, "same_cycle_err");
    nxt();
    idle();
    expect_out(K_BUSY, 0, "same_cycle_single_pending");
    expect_out(K_ERR, 0, "same_cycle_err_after");
    nxt();

    // Three-cycle flush; second branch during flush is ignored
    drive(0, 4'd0, 4'd0, 0, 0, 4'd0, 1, 0, 4'd0);
    expect_out(K_FLUSH, 1, "flush_t0");
    nxt();
    drive(0, 4'd0, 4'd0, 0, 0, 4'd0, 1, 0, 4'd0);
    expect_out(K_FLUSH, 1, "flush_t1");
    nxt();
    idle();
    expect_out(K_FLUSH, 1, "flush_t2");
    nxt();
    expect_out(K_FLUSH, 0, "flush_t3_done");
    expect_out(K_FCNT, 1, "flush_count_once");
    nxt();

    // Flush overrides a pending RAW stall and blocks issue
    drive(1, 4'd0, 4'd0, 0, 1, 4'd4, 0, 0, 4'd0);
    nxt();
    drive(1, 4'd4, 4'd0, 0, 1, 4'd11, 1, 0, 4'd0);
    expect_out(K_FLUSH, 1, "fvh_flush");
    expect_out(K_HAZ, 0, "fvh_hazard_masked");
    nxt();
    drive(1, 4'd4, 4'd0, 0, 1, 4'd11, 0, 0, 4'd0);
    expect_out(K_HAZ, 0, "fvh_hazard_masked2");
    expect_out(K_BUSY, 32'h0010, "fvh_no_issue");
    nxt();
    expect_out(K_FLUSH, 1, "fvh_flush3");
    nxt();
    drive(1, 4'd4, 4'd0, 0, 0, 4'd0, 0, 1, 4'd4);
    expect_out(K_FLUSH, 0, "fvh_flush_done");
    expect_out(K_HAZ, 1, "fvh_stall_resumes");
    expect_out(K_BUSY, 32'h0010, "fvh_busy_unchanged");
    expect_out(K_FCNT, 2, "fvh_flush_count");
    expect_out(K_STALL, 3, "fvh_stall_not_counted");
    nxt();
    idle();
    expect_out(K_BUSY, 0, "fvh_busy_cleared");
    expect_out(K_STALL, 4, "fvh_stall_count");
    nxt();

    // Underflow: retire R7 with nothing pending
    drive(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd7);
    expect_out(K_ERR, 0, "underflow_before");
    nxt();
    idle();
    expect_out(K_ERR, 1, "underflow_err");
    expect_out(K_BUSY, 0, "underflow_pend_zero");
    nxt();
    nxt();
    expect_out(K_ERR, 1, "underflow_err_sticky");
    nxt();

    // Reset mid-flush with two writes pending on R3
    drive(1, 4'd0, 4'd0, 0, 1, 4'd3, 0, 0, 4'd0);
    nxt();
    nxt();
    drive(0, 4'd0, 4'd0, 0, 0, 4'd0, 1, 0, 4'd0);
    expect_out(K_BUSY, 32'h0008, "rst_setup_busy_r3");
    expect_out(K_FLUSH, 1, "rst_setup_flush");
    nxt();
    idle();
    expect_out(K_FLUSH, 1, "rst_setup_in_flush");
    expect_out(K_FCNT, 3, "rst_setup_fcount");
    expect_out(K_STALL, 4, "rst_setup_stall");
    expect_out(K_ERR, 1, "rst_setup_err");
    nxt();
    drive(1, 4'd3, 4'd0, 0, 0, 4'd0, 1, 0, 4'd0);
    rst = 1'b0;
    expect_out(K_HAZ, 0, "rst_hazard");
    expect_out(K_FLUSH, 0, "rst_flush");
    expect_out(K_BUSY, 0, "rst_busy");
    expect_out(K_STALL, 0, "rst_stall");
    expect_out(K_FCNT, 0, "rst_fcount");
    expect_out(K_ERR, 0, "rst_err");
    nxt();
    rst = 1'b1;
    idle();
    expect_out(K_FLUSH, 0, "after_rst_flush");
    expect_out(K_BUSY, 0, "after_rst_busy");
    expect_out(K_ERR, 0, "after_rst_err");
    nxt();
    nxt();

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
